// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults, busy-FSM state type and register-zero constant for hazard_ctrl.
`default_nettype none
package hazard_pkg;
  localparam int TW_DEF       = 2;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CW_DEF       = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;
endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// md_busy_tracker: counts down the mult/div occupancy after an issue from E.
`default_nettype none
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_t       state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
            state <= BUSY;
          end
        end
        BUSY: begin
          // A start seen here is a protocol violation and is deliberately ignored.
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);

`ifndef SYNTHESIS
  a_no_restart_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(start && state == BUSY)
  ) else $error("md_busy_tracker: md_start_E asserted while unit busy");
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand and mult/div hazard detection producing stall/flush controls.
// Optional HAZARD_PERF_EN adds saturating stall_cnt / md_stall_cnt outputs.
`default_nettype none
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TW       = TW_DEF,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    a1_D,
  input  logic [4:0]    a2_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic [4:0]    a3_E,
  input  logic [4:0]    a3_M,
  input  logic [TW-1:0] tnew_E,
  input  logic [TW-1:0] tnew_M,
  input  logic          we_E,
  input  logic          we_M,
  input  logic          md_start_E,
  input  logic          md_is_div_E,
  input  logic          md_use_D,
  output logic          en_F,
  output logic          en_D,
  output logic          flush_E,
  output logic          md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   md_stall_cnt
`endif
);

  logic hz_op;
  logic hz_md;
  logic stall;

  // W is never checked: its result is already in the register file (Tnew = 0).
  function automatic logic src_hz(input logic [4:0] a_src, input logic [TW-1:0] tuse,
                                  input logic [4:0] a3, input logic [TW-1:0] tnew,
                                  input logic we);
    return we && (a3 == a_src) && (a_src != REG_ZERO) && (tuse < tnew);
  endfunction

  always_comb begin
    hz_op = src_hz(a1_D, tuse_rs_D, a3_E, tnew_E, we_E) |
            src_hz(a1_D, tuse_rs_D, a3_M, tnew_M, we_M) |
            src_hz(a2_D, tuse_rt_D, a3_E, tnew_E, we_E) |
            src_hz(a2_D, tuse_rt_D, a3_M, tnew_M, we_M);
    hz_md = md_use_D && (md_start_E || md_busy);
    stall = hz_op | hz_md;
  end

  assign en_F    = !stall;
  assign en_D    = !stall;
  assign flush_E = stall;

  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CW       (CW)
  ) u_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_E),
    .is_div (md_is_div_E),
    .busy   (md_busy)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] md_stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz_md && !hz_op && (md_stall_cnt_q != 32'hFFFF_FFFF))
        md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (default parameters).
`default_nettype none
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] a1_D, a2_D, a3_E, a3_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic       we_E, we_M, md_start_E, md_is_div_E, md_use_D;
  logic       en_F, en_D, flush_E, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
  logic [31:0] sc0, mc0;
`endif

  int tests = 0;
  int fails = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .a1_D        (a1_D),
    .a2_D        (a2_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .a3_E        (a3_E),
    .a3_M        (a3_M),
    .tnew_E      (tnew_E),
    .tnew_M      (tnew_M),
    .we_E        (we_E),
    .we_M        (we_M),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .md_use_D    (md_use_D),
    .en_F        (en_F),
    .en_D        (en_D),
    .flush_E     (flush_E),
    .md_busy     (md_busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    a1_D = 5'd0; a2_D = 5'd0; a3_E = 5'd0; a3_M = 5'd0;
    tuse_rs_D = 2'd0; tuse_rt_D = 2'd0; tnew_E = 2'd0; tnew_M = 2'd0;
    we_E = 1'b0; we_M = 1'b0;
    md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0;
    #3;
    tests++;
    if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    tests++;
    if (en_F !== 1'b1 || flush_E !== 1'b0) begin
      fails++; $display("FAIL reset_idle_ctrl: en_F=%b flush_E=%b want 1/0", en_F, flush_E);
    end
    // Stall controls stay combinational while in reset
    a3_E = 5'd8; we_E = 1'b1; tnew_E = 2'd2; a1_D = 5'd8; tuse_rs_D = 2'd1;
    #1;
    tests++;
    if (flush_E !== 1'b1 || en_D !== 1'b0) begin
      fails++; $display("FAIL reset_comb_stall: flush_E=%b en_D=%b want 1/0", flush_E, en_D);
    end
    quiet();
    next_cyc();
    reset = 1'b1;
    next_cyc();
  endtask

  task automatic test_load_use();
    next_cyc();
    a3_E = 5'd8; we_E = 1'b1; tnew_E = 2'd2; a1_D = 5'd8; tuse_rs_D = 2'd1;
    #1;
    tests++;
    if (en_F !== 1'b0 || en_D !== 1'b0 || flush_E !== 1'b1) begin
      fails++; $display("FAIL load_use: en_F=%b en_D=%b flush_E=%b want 0/0/1", en_F, en_D, flush_E);
    end
    tnew_E = 2'd1;
    #1;
    tests++;
    if (en_F !== 1'b1 || flush_E !== 1'b0) begin
      fails++; $display("FAIL load_use_equal: en_F=%b flush_E=%b want 1/0", en_F, flush_E);
    end
    tnew_E = 2'd2; we_E = 1'b0;
    #1;
    tests++;
    if (flush_E !== 1'b0) begin fails++; $display("FAIL load_use_no_we: got %b want 0", flush_E); end
    quiet();
  endtask

  task automatic test_zero_filter();
    next_cyc();
    a3_E = 5'd0; we_E = 1'b1; tnew_E = 2'd2; a1_D = 5'd0; tuse_rs_D = 2'd0;
    #1;
    tests++;
    if (en_F !== 1'b1 || flush_E !== 1'b0) begin
      fails++; $display("FAIL zero_filter: en_F=%b flush_E=%b want 1/0", en_F, flush_E);
    end
    quiet();
  endtask

  task automatic test_m_stage_rt();
    next_cyc();
    a3_M = 5'd9; we_M = 1'b1; tnew_M = 2'd1; a2_D = 5'd9; tuse_rt_D = 2'd0;
    #1;
    tests++;
    if (flush_E !== 1'b1 || en_F !== 1'b0) begin
      fails++; $display("FAIL m_stage_rt: flush_E=%b en_F=%b want 1/0", flush_E, en_F);
    end
    tuse_rt_D = 2'd1;
    #1;
    tests++;
    if (flush_E !== 1'b0) begin fails++; $display("FAIL m_stage_rt_ok: got %b want 0", flush_E); end
    tuse_rt_D = 2'd0; a2_D = 5'd10;
    #1;
    tests++;
    if (flush_E !== 1'b0) begin fails++; $display("FAIL m_stage_rt_diff_reg: got %b want 0", flush_E); end
    quiet();
  endtask

  task automatic test_multiply();
    next_cyc();
    md_use_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b0;
    #1;
    tests++;
    if (flush_E !== 1'b1 || md_busy !== 1'b0) begin
      fails++; $display("FAIL mul_issue: flush_E=%b md_busy=%b want 1/0", flush_E, md_busy);
    end
    next_cyc();
    md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      tests++;
      if (md_busy !== 1'b1 || en_F !== 1'b0) begin
        fails++; $display("FAIL mul_busy_c%0d: md_busy=%b en_F=%b want 1/0", i, md_busy, en_F);
      end
      next_cyc();
    end
    #1;
    tests++;
    if (md_busy !== 1'b0 || en_F !== 1'b1) begin
      fails++; $display("FAIL mul_release: md_busy=%b en_F=%b want 0/1", md_busy, en_F);
    end
    quiet();
  endtask

  task automatic test_divide_reset();
    next_cyc();
    md_start_E = 1'b1; md_is_div_E = 1'b1;
    next_cyc();
    md_start_E = 1'b0; md_is_div_E = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      tests++;
      if (md_busy !== 1'b1) begin fails++; $display("FAIL div_busy_c%0d: got %b want 1", i, md_busy); end
      next_cyc();
    end
    reset = 1'b0;
    #1;
    tests++;
    if (md_busy !== 1'b0 || dut.u_busy.state !== IDLE) begin
      fails++; $display("FAIL div_abort: md_busy=%b state=%0d want 0/0", md_busy, dut.u_busy.state);
    end
    next_cyc();
    reset = 1'b1;
    md_use_D = 1'b1;
    #1;
    tests++;
    if (en_F !== 1'b1 || flush_E !== 1'b0) begin
      fails++; $display("FAIL div_after_reset: en_F=%b flush_E=%b want 1/0", en_F, flush_E);
    end
    next_cyc();
    tests++;
    if (md_busy !== 1'b0) begin fails++; $display("FAIL div_stays_idle: got %b want 0", md_busy); end
    quiet();
  endtask

  task automatic test_overlap();
    next_cyc();
    a3_E = 5'd8; we_E = 1'b1; tnew_E = 2'd2; a1_D = 5'd8; tuse_rs_D = 2'd1;
    md_start_E = 1'b1; md_use_D = 1'b1;
    #1;
    tests++;
    if (flush_E !== 1'b1 || en_D !== 1'b0) begin
      fails++; $display("FAIL overlap: flush_E=%b en_D=%b want 1/0", flush_E, en_D);
    end
`ifdef HAZARD_PERF_EN
    sc0 = stall_cnt; mc0 = md_stall_cnt;
`endif
    next_cyc();
    quiet();
`ifdef HAZARD_PERF_EN
    #1;
    tests++;
    if (stall_cnt !== sc0 + 32'd1) begin
      fails++; $display("FAIL overlap_stall_cnt: got %0d want %0d", stall_cnt, sc0 + 32'd1);
    end
    tests++;
    if (md_stall_cnt !== mc0) begin
      fails++; $display("FAIL overlap_md_stall_cnt: got %0d want %0d", md_stall_cnt, mc0);
    end
`endif
    repeat (6) next_cyc();
    tests++;
    if (md_busy !== 1'b0) begin fails++; $display("FAIL overlap_drain: got %b want 0", md_busy); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_saturation();
    next_cyc();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    a3_E = 5'd8; we_E = 1'b1; tnew_E = 2'd2; a1_D = 5'd8; tuse_rs_D = 2'd1;
    next_cyc();
    tests++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_first: got %h want ffffffff", stall_cnt); end
    next_cyc();
    tests++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hold: got %h want ffffffff", stall_cnt); end
    quiet();
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_zero_filter();
    test_m_stage_rt();
    test_multiply();
    test_divide_reset();
    test_overlap();
`ifdef HAZARD_PERF_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
